// File: rtl/expr_arbiter.sv
// Two-requester arbiter feeding a single-digit infix checker/evaluator ('*' binds tighter than '+').
// Optional idle timeout on the granted requester: define EXPR_TIMEOUT_EN.
module expr_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic        res_valid,
   output logic        res_ok,
   output logic [15:0] res_val,
   output logic        res_src,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NUM,
      S_OPR,
      S_DRAIN,
      S_REPORT
   } state_t;

   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_MUL  = 8'h2A;
   localparam logic [7:0] CH_TERM = 8'h3B;
   localparam logic [7:0] CH_ZERO = 8'h30;
   localparam logic [7:0] CH_NINE = 8'h39;

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [15:0] sum_q, sum_d;
   logic [15:0] prod_q, prod_d;
   logic        mul_q, mul_d;
   logic        res_valid_q, res_valid_d;
   logic        res_ok_q, res_ok_d;
   logic [15:0] res_val_q, res_val_d;
   logic        res_src_q, res_src_d;

   logic        active;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        accept;
   logic        is_digit;
   logic [7:0]  digit;
   logic [15:0] dval;

   assign active     = (state_q == S_NUM) || (state_q == S_OPR) || (state_q == S_DRAIN);
   assign in_valid   = gnt_q ? req1_valid : req0_valid;
   assign in_data    = gnt_q ? req1_data : req0_data;
   assign accept     = active && in_valid;
   assign is_digit   = (in_data >= CH_ZERO) && (in_data <= CH_NINE);
   assign digit      = in_data - CH_ZERO;
   assign dval       = {8'd0, digit};

   assign req0_ready = active && !gnt_q;
   assign req1_ready = active && gnt_q;
   assign busy       = (state_q != S_IDLE);
   assign res_valid  = res_valid_q;
   assign res_ok     = res_ok_q;
   assign res_val    = res_val_q;
   assign res_src    = res_src_q;

`ifdef EXPR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
`else
   logic tmo_unused;
   assign tmo_unused = (TIMEOUT == 0);
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      sum_d       = sum_q;
      prod_d      = prod_q;
      mul_d       = mul_q;
      res_valid_d = 1'b0;
      res_ok_d    = res_ok_q;
      res_val_d   = res_val_q;
      res_src_d   = res_src_q;

      // Result outputs are loaded on the edge that enters REPORT so they are valid with the pulse.
      case (state_q)
         S_IDLE: begin
            sum_d  = '0;
            prod_d = '0;
            mul_d  = 1'b0;
            if (req0_valid || req1_valid) begin
               gnt_d   = (req0_valid && req1_valid) ? !last_q : req1_valid;
               state_d = S_NUM;
            end
         end
         S_NUM: begin
            if (accept) begin
               if (is_digit) begin
                  prod_d  = mul_q ? (prod_q * dval) : dval;
                  state_d = S_OPR;
               end else if (in_data == CH_TERM) begin
                  res_valid_d = 1'b1;
                  res_ok_d    = 1'b0;
                  res_val_d   = '0;
                  res_src_d   = gnt_q;
                  state_d     = S_REPORT;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_OPR: begin
            if (accept) begin
               if (in_data == CH_PLUS) begin
                  sum_d   = sum_q + prod_q;
                  mul_d   = 1'b0;
                  state_d = S_NUM;
               end else if (in_data == CH_MUL) begin
                  mul_d   = 1'b1;
                  state_d = S_NUM;
               end else if (in_data == CH_TERM) begin
                  res_valid_d = 1'b1;
                  res_ok_d    = 1'b1;
                  res_val_d   = sum_q + prod_q;
                  res_src_d   = gnt_q;
                  state_d     = S_REPORT;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (accept && (in_data == CH_TERM)) begin
               res_valid_d = 1'b1;
               res_ok_d    = 1'b0;
               res_val_d   = '0;
               res_src_d   = gnt_q;
               state_d     = S_REPORT;
            end
         end
         S_REPORT: begin
            last_d  = gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef EXPR_TIMEOUT_EN
      tmo_d = tmo_q;
      if (!active || accept) begin
         tmo_d = '0;
      end else if (!in_valid) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d       = '0;
            res_valid_d = 1'b1;
            res_ok_d    = 1'b0;
            res_val_d   = '0;
            res_src_d   = gnt_q;
            state_d     = S_REPORT;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= S_IDLE;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         sum_q       <= '0;
         prod_q      <= '0;
         mul_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_ok_q    <= 1'b0;
         res_val_q   <= '0;
         res_src_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         sum_q       <= sum_d;
         prod_q      <= prod_d;
         mul_q       <= mul_d;
         res_valid_q <= res_valid_d;
         res_ok_q    <= res_ok_d;
         res_val_q   <= res_val_d;
         res_src_q   <= res_src_d;
      end
   end

`ifdef EXPR_TIMEOUT_EN
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

endmodule

// File: tb/tb_expr_arbiter.sv
// Self-checking bench for expr_arbiter: per-requester byte queues, expression-level reference model.
module tb_expr_arbiter;

   logic        clk;
   logic        clr_n;
   logic        req0_valid;
   logic [7:0]  req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [7:0]  req1_data;
   logic        req1_ready;
   logic        res_valid;
   logic        res_ok;
   logic [15:0] res_val;
   logic        res_src;
   logic        busy;

   expr_arbiter #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ok     (res_ok),
      .res_val    (res_val),
      .res_src    (res_src),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rep_cnt = 0;
   int last_rep_cyc = 0;
   bit gap_en = 0;
   bit prev_res_valid = 0;
   logic        last_ok;
   logic [15:0] last_val;
   logic        last_src;

   logic [7:0]  q0[$], q1[$], seg0[$], seg1[$];
   logic [16:0] e0[$], e1[$];
   logic        src_log[$], ok_log[$];
   logic [15:0] val_log[$];

   // Reference: {ok, value} of one expression body (bytes before ';').
   function automatic logic [16:0] model(input logic [7:0] e[$]);
      int n;
      int total;
      int term;
      int d;
      n = e.size();
      total = 0;
      if (n % 2 == 0) return 17'd0;
      for (int i = 0; i < n; i++) begin
         if (i % 2 == 0) begin
            if (e[i] < 8'h30 || e[i] > 8'h39) return 17'd0;
         end else if (e[i] != 8'h2B && e[i] != 8'h2A) begin
            return 17'd0;
         end
      end
      term = int'(e[0]) - 48;
      for (int i = 1; i < n; i += 2) begin
         d = int'(e[i+1]) - 48;
         if (e[i] == 8'h2A) term = (term * d) % 65536;
         else begin
            total = (total + term) % 65536;
            term = d;
         end
      end
      return {1'b1, 16'((total + term) % 65536)};
   endfunction

   task automatic push_byte(input int src, input logic [7:0] b);
      if (src == 0) begin
         q0.push_back(b);
         if (b == 8'h3B) begin
            e0.push_back(model(seg0));
            seg0.delete();
         end else seg0.push_back(b);
      end else begin
         q1.push_back(b);
         if (b == 8'h3B) begin
            e1.push_back(model(seg1));
            seg1.delete();
         end else seg1.push_back(b);
      end
   endtask

   task automatic enqueue_str(input int src, input string s);
      for (int i = 0; i < s.len(); i++) push_byte(src, s[i]);
   endtask

   task automatic tick();
      logic a0, a1;
      logic [7:0] b;
      logic [16:0] exp;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (a0 && q0.size() != 0) b = q0.pop_front();
      if (a1 && q1.size() != 0) b = q1.pop_front();
      checks++;
      if (req0_ready && req1_ready) begin
         errors++;
         $display("FAIL both_ready: req0_ready=%0b req1_ready=%0b required one low (cycle %0d)", req0_ready, req1_ready, cyc);
      end
      if (res_valid) begin
         checks++;
         if (prev_res_valid) begin
            errors++;
            $display("FAIL pulse_width: res_valid high two cycles running, required single pulse (cycle %0d)", cyc);
         end
         rep_cnt++;
         last_rep_cyc = cyc;
         last_ok = res_ok;
         last_val = res_val;
         last_src = res_src;
         src_log.push_back(res_src);
         ok_log.push_back(res_ok);
         val_log.push_back(res_val);
         checks++;
         if ((res_src ? e1.size() : e0.size()) == 0) begin
            errors++;
            $display("FAIL unexpected_report: src=%0d ok=%0b val=%0d, required no report (cycle %0d)", res_src, res_ok, res_val, cyc);
         end else begin
            exp = res_src ? e1.pop_front() : e0.pop_front();
            if ({res_ok, res_val} !== exp) begin
               errors++;
               $display("FAIL result_src%0d: got ok=%0b val=%0d, required ok=%0b val=%0d (cycle %0d)", res_src, res_ok, res_val, exp[16], exp[15:0], cyc);
            end
         end
      end
      prev_res_valid = res_valid;
      req0_valid = (q0.size() != 0) && (!gap_en || $urandom_range(0, 3) != 0);
      req0_data  = (q0.size() != 0) ? q0[0] : 8'($urandom_range(0, 255));
      req1_valid = (q1.size() != 0) && (!gap_en || $urandom_range(0, 3) != 0);
      req1_data  = (q1.size() != 0) ? q1[0] : 8'($urandom_range(0, 255));
   endtask

   task automatic run_done(input int limit);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || e0.size() != 0 || e1.size() != 0 || busy) && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL drain_budget: %0d cycles used with q0=%0d q1=%0d e0=%0d e1=%0d pending, required completion", n, q0.size(), q1.size(), e0.size(), e1.size());
      end
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      q0.delete(); q1.delete(); seg0.delete(); seg1.delete(); e0.delete(); e1.delete();
      repeat (2) tick();
      clr_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      clr_n = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b required 0", res_valid); end
      checks++; if (res_ok !== 1'b0) begin errors++; $display("FAIL reset_res_ok: got %0b required 0", res_ok); end
      checks++; if (res_val !== 16'd0) begin errors++; $display("FAIL reset_res_val: got %0d required 0", res_val); end
      checks++; if (res_src !== 1'b0) begin errors++; $display("FAIL reset_res_src: got %0b required 0", res_src); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready}); end
      clr_n = 1'b1;
      tick();
   endtask

   task automatic test_single_expr();
      int first;
      bit r1_seen;
      int base;
      base = rep_cnt;
      enqueue_str(0, "3+4*5;");
      tick();
      first = cyc;
      tick();
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL grant_latency: req0_ready=%0b one cycle after valid, required 1", req0_ready); end
      r1_seen = 0;
      while ((q0.size() != 0 || busy) && cyc - first < 50) begin
         tick();
         if (req1_ready) r1_seen = 1;
      end
      checks++; if (rep_cnt - base != 1) begin errors++; $display("FAIL single_count: got %0d reports required 1", rep_cnt - base); end
      checks++; if (last_rep_cyc - first != 7) begin errors++; $display("FAIL single_latency: got %0d cycles required 7", last_rep_cyc - first); end
      checks++; if ({last_ok, last_val, last_src} !== {1'b1, 16'd23, 1'b0}) begin errors++; $display("FAIL single_value: got ok=%0b val=%0d src=%0b required ok=1 val=23 src=0", last_ok, last_val, last_src); end
      checks++; if (r1_seen) begin errors++; $display("FAIL single_r1_ready: req1_ready went high, required 0"); end
   endtask

   task automatic test_round_robin();
      do_reset();
      src_log.delete(); val_log.delete();
      enqueue_str(0, "2*3;9;");
      enqueue_str(1, "2*3;9;");
      run_done(200);
      checks++;
      if (src_log.size() != 4) begin
         errors++;
         $display("FAIL rr_count: got %0d reports required 4", src_log.size());
      end else begin
         if ({src_log[0], src_log[1], src_log[2], src_log[3]} !== 4'b0101) begin
            errors++;
            $display("FAIL rr_order: got %b%b%b%b required 0101", src_log[0], src_log[1], src_log[2], src_log[3]);
         end
         checks++;
         if (val_log[0] !== 16'd6 || val_log[1] !== 16'd6) begin
            errors++;
            $display("FAIL rr_values: got %0d,%0d required 6,6", val_log[0], val_log[1]);
         end
      end
   endtask

   task automatic test_illegal();
      int first;
      ok_log.delete(); val_log.delete(); src_log.delete();
      enqueue_str(1, "3+*4;5;");
      run_done(200);
      checks++;
      if (ok_log.size() != 2) begin
         errors++;
         $display("FAIL drain_count: got %0d reports required 2", ok_log.size());
      end else if ({ok_log[0], val_log[0], ok_log[1], val_log[1], src_log[1]} !== {1'b0, 16'd0, 1'b1, 16'd5, 1'b1}) begin
         errors++;
         $display("FAIL drain_results: got ok=%0b val=%0d then ok=%0b val=%0d src=%0b required 0/0 then 1/5 src 1", ok_log[0], val_log[0], ok_log[1], val_log[1], src_log[1]);
      end
      enqueue_str(0, ";");
      tick();
      first = cyc;
      run_done(50);
      checks++; if (last_rep_cyc - first != 2 || last_ok !== 1'b0) begin errors++; $display("FAIL lone_term: got latency %0d ok=%0b required latency 2 ok=0", last_rep_cyc - first, last_ok); end
      enqueue_str(0, "7+;");
      run_done(50);
      checks++; if ({last_ok, last_val} !== 17'd0) begin errors++; $display("FAIL trailing_op: got ok=%0b val=%0d required ok=0 val=0", last_ok, last_val); end
      enqueue_str(0, "9*9*9*9*9*9;");
      run_done(100);
      checks++; if ({last_ok, last_val} !== {1'b1, 16'd7153}) begin errors++; $display("FAIL wrap_product: got ok=%0b val=%0d required ok=1 val=7153", last_ok, last_val); end
   endtask

   task automatic test_reset_mid();
      int base;
      int n;
      base = rep_cnt;
      enqueue_str(0, "5+6");
      n = 0;
      while (q0.size() != 0 && n < 50) begin tick(); n++; end
      clr_n = 1'b0;
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({res_valid, res_ok, res_val, res_src, busy, req0_ready, req1_ready} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got valid=%0b ok=%0b val=%0d src=%0b busy=%0b rdy=%0b%0b required all 0", res_valid, res_ok, res_val, res_src, busy, req0_ready, req1_ready);
      end
      q0.delete(); seg0.delete();
      repeat (3) tick();
      clr_n = 1'b1;
      checks++; if (rep_cnt != base) begin errors++; $display("FAIL mid_reset_report: got %0d reports required 0", rep_cnt - base); end
      enqueue_str(1, "1;");
      run_done(50);
      checks++; if ({last_ok, last_val, last_src} !== {1'b1, 16'd1, 1'b1}) begin errors++; $display("FAIL after_reset: got ok=%0b val=%0d src=%0b required ok=1 val=1 src=1", last_ok, last_val, last_src); end
   endtask

   task automatic test_timeout();
      int base;
      int n;
      int empty_cyc;
      do_reset();
      base = rep_cnt;
      enqueue_str(0, "4+");
      n = 0;
      while (q0.size() != 0 && n < 50) begin tick(); n++; end
      empty_cyc = cyc;
      enqueue_str(1, "1;");
`ifdef EXPR_TIMEOUT_EN
      e0.push_back(17'd0);
      seg0.delete();
      n = 0;
      while (rep_cnt == base && n < 100) begin tick(); n++; end
      checks++; if (rep_cnt == base || last_rep_cyc - empty_cyc != 16) begin errors++; $display("FAIL timeout_latency: got %0d idle cycles required 16", last_rep_cyc - empty_cyc); end
      run_done(100);
      checks++; if ({last_ok, last_val, last_src} !== {1'b1, 16'd1, 1'b1}) begin errors++; $display("FAIL timeout_next_grant: got ok=%0b val=%0d src=%0b required ok=1 val=1 src=1", last_ok, last_val, last_src); end
`else
      repeat (40) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %0b required 1", busy); end
      checks++; if (rep_cnt != base) begin errors++; $display("FAIL hold_report: got %0d reports required 0", rep_cnt - base); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL hold_r1_ready: got %0b required 0", req1_ready); end
      do_reset();
`endif
   endtask

   task automatic gen_expr(input int src);
      int terms;
      logic [7:0] junk[5];
      junk = '{8'h78, 8'h3B, 8'h2B, 8'h2A, 8'h35};
      terms = int'($urandom_range(1, 5));
      for (int t = 0; t < terms; t++) begin
         push_byte(src, 8'h30 + 8'($urandom_range(0, 9)));
         if ($urandom_range(0, 9) == 0) push_byte(src, junk[$urandom_range(0, 4)]);
         if (t < terms - 1) push_byte(src, ($urandom_range(0, 1) == 1) ? 8'h2A : 8'h2B);
      end
      push_byte(src, 8'h3B);
   endtask

   task automatic test_random();
      gap_en = 1;
      for (int k = 0; k < 60; k++) begin
         gen_expr(0);
         gen_expr(1);
      end
      run_done(20000);
      gap_en = 0;
   endtask

   initial begin
      clr_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data = 8'h00;
      req1_data = 8'h00;
      test_reset();
      test_single_expr();
      test_round_robin();
      test_illegal();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/expr_arbiter.md
# expr_arbiter

Shared expression front-end that arbitrates two byte-stream requesters onto one single-digit infix-expression checker and evaluator. It grants one requester a whole expression at a time, through the terminating `;`, and checks the grammar `digit (op digit)* ;`, with op being `+` or `*`. It evaluates the value with `*` binding tighter than `+` and reports result, legality and source. It sits between the character sources and downstream result consumers.

## Interface
Parameters:
- `TIMEOUT`, 16: idle-cycle limit for a granted requester; used only when `EXPR_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock, rising edge.
- `clr_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in 8: requester 0 ASCII byte.
- `req0_ready` out 1: byte accepted when `req0_valid & req0_ready`.
- `req1_valid`, `req1_data`, `req1_ready`: same for requester 1.
- `res_valid` out 1: one-cycle result pulse.
- `res_ok` out 1: expression legal.
- `res_val` out 16: expression value, mod 2^16; 0 when illegal.
- `res_src` out 1: requester that produced the result.
- `busy` out 1: a requester currently holds the grant.

## Operation
States:
- **IDLE**
  - If any `reqX_valid`, latch the grant and go to NUM.
  - If both are valid, grant the requester not served last. After reset, requester 0 wins.
  - Clear `sum=0`, `prod=0`, `op=+`.
- **NUM** (expect a digit)
  - Digit `d`: if `op=+`, set `prod<=d`; if `op=*`, set `prod<=prod*d`. Go to OPR.
  - Any other byte, including `;`, is illegal:
    - if the byte is `;`, go to REPORT with ok=0;
    - otherwise go to DRAIN.
- **OPR** (expect an operator or the terminator)
  - `+`: `sum<=sum+prod`, `op<=+`, go to NUM.
  - `*`: `op<=*`, go to NUM.
  - `;`: result is `sum+prod`, go to REPORT with ok=1.
  - Anything else: go to DRAIN.
- **DRAIN**
  - Accept and discard bytes up to and including `;`, then go to REPORT with ok=0.
- **REPORT**
  - Assert `res_valid` for one cycle.
  - Update `res_ok`, `res_val` (0 if illegal) and `res_src`.
  - Record the served requester for round-robin.
  - Go to IDLE.

Rules:
- `reqX_ready` is high only for the granted requester, only in NUM, OPR or DRAIN. The other requester's ready stays 0.
- At most one byte is accepted per cycle. If valid is low in NUM, OPR or DRAIN, the state holds.
- Arithmetic: `sum`, `prod` and the result are 16 bits and wrap modulo 2^16. Digits are the values 0-9; the ASCII range is `"0"`..`"9"`.
- `res_ok`, `res_val` and `res_src` hold their last reported values until the next REPORT.
- `busy` is 1 in NUM, OPR, DRAIN and REPORT.

## Timing
- Reset (`clr_n`=0, asynchronous):
  - state goes to IDLE;
  - every output is 0: `res_valid`, `res_ok`, `res_val`, `res_src`, `busy`, `req0_ready`, `req1_ready`;
  - the round-robin pointer is set so requester 0 wins next;
  - `sum`, `prod` and `op` are cleared.
- Reset mid-expression discards the partial expression and produces no report.
- Grant latency: valid seen in IDLE at cycle N gives ready high at N+1, so the first byte is accepted at N+1 at the earliest.
- Terminator accepted at cycle T:
  - `res_valid`=1 and the outputs update at T+1;
  - IDLE at T+2;
  - the next grant gives ready at T+3.
- Holding valid throughout, an expression of L bytes takes L+3 cycles from first valid to the next grant.
- The grant never changes mid-expression, even if the granted requester drops valid.

## Configuration
- `EXPR_TIMEOUT_EN` defined:
  - a counter clears on every accepted byte and counts cycles in NUM, OPR or DRAIN while the granted valid is low;
  - on reaching `TIMEOUT`, go to REPORT with ok=0, `res_val`=0, and release the grant.
- `EXPR_TIMEOUT_EN` undefined: no counter; the grant is held indefinitely until `;`.

## Test plan
- Requester 0 sends `3+4*5;` back-to-back -> one `res_valid` pulse with ok=1, val=23, src=0; `req1_ready` stays 0 throughout.
- Both requesters valid from reset, each sending `2*3;` then `9;` -> first report src=0 val=6, second src=1 val=6; then alternation continues.
- Requester 1 sends `3+*4;5;` -> first report ok=0 val=0 after `;` (DRAIN consumes `4;`); next report ok=1 val=5.
- `;` alone -> ok=0 at T+1. `7+;` -> ok=0. `9*9*9*9*9*9;` -> ok=1, val=7153 (531441 mod 65536).
- `clr_n` pulsed low after `5+6` -> all outputs 0 immediately, no report. The following `1;` from requester 1 alone -> ok=1, val=1, src=1.
- With `EXPR_TIMEOUT_EN` and TIMEOUT=16, requester 0 sends `4+` then idles -> report ok=0 val=0 exactly 16 idle cycles later; a pending requester 1 is then granted. Without the macro -> no report, `busy` stays 1.
